// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master (core m0, DMA m1) round-robin arbiter in front of a
// single-ported data memory. Each access runs IDLE -> ACC -> RESP, so the
// response arrives two cycles after the grant edge and a new access can start
// every third cycle. Illegal byte masks are flagged and never write memory.
module dmem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [3:0]      m0_amp,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [3:0]      m1_amp,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_err,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_err,
    output logic            mem_we,
    output logic [3:0]      mem_amp,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Legal masks: full word, either aligned halfword, any single byte.
    function automatic logic amp_legal(input logic [3:0] amp);
        case (amp)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: amp_legal = 1'b1;
            default:                            amp_legal = 1'b0;
        endcase
    endfunction

    state_t            state_r, state_nxt_s;
    logic              last_r;      // last granted master: 0 = m0, 1 = m1
    logic              id_r;        // master owning the access in flight
    logic              we_r;
    logic [3:0]        amp_r;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic              err_r;
    logic              m0_rvalid_r, m1_rvalid_r;
    logic              m0_err_r, m1_err_r;
    logic [XLEN-1:0]   m0_rdata_r, m1_rdata_r;

    logic              win_s;       // arbitration winner: 0 = m0, 1 = m1
    logic              grant_s;
    logic              sel_we_s;
    logic [3:0]        sel_amp_s;
    logic [XLEN-1:0]   sel_addr_s;
    logic [XLEN-1:0]   sel_wdata_s;

    // Round-robin winner selection and request fields of the winner.
    always_comb begin
        win_s       = 1'b0;
        sel_we_s    = m0_we;
        sel_amp_s   = m0_amp;
        sel_addr_s  = m0_addr;
        sel_wdata_s = m0_wdata;
        if (m0_req && m1_req) begin
            win_s = ~last_r;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            sel_we_s    = m1_we;
            sel_amp_s   = m1_amp;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_amp_s   = m0_amp;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
    end

    // Grant only from IDLE; reset masks it so outputs are zero while held.
    assign grant_s = (state_r == IDLE) && (m0_req || m1_req) && !reset;
    assign m0_gnt  = grant_s && !win_s;
    assign m1_gnt  = grant_s &&  win_s;

    // Next-state logic: requests are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC:     state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, latched access fields, and per-master response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            id_r        <= 1'b0;
            we_r        <= 1'b0;
            amp_r       <= 4'b0000;
            addr_r      <= {XLEN{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            err_r       <= 1'b0;
            m0_rvalid_r <= 1'b0;
            m1_rvalid_r <= 1'b0;
            m0_err_r    <= 1'b0;
            m1_err_r    <= 1'b0;
            m0_rdata_r  <= {XLEN{1'b0}};
            m1_rdata_r  <= {XLEN{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            m0_rvalid_r <= 1'b0;
            m1_rvalid_r <= 1'b0;
            m0_err_r    <= 1'b0;
            m1_err_r    <= 1'b0;
            if (grant_s) begin
                last_r  <= win_s;
                id_r    <= win_s;
                we_r    <= sel_we_s;
                amp_r   <= sel_amp_s;
                addr_r  <= sel_addr_s;
                wdata_r <= sel_wdata_s;
                err_r   <= !amp_legal(sel_amp_s);
            end
            // The word read during ACC is returned for stores too; for a
            // store it is the value before the write lands.
            if (state_r == ACC) begin
                if (id_r) begin
                    m1_rvalid_r <= 1'b1;
                    m1_err_r    <= err_r;
                    m1_rdata_r  <= mem_rd;
                end else begin
                    m0_rvalid_r <= 1'b1;
                    m0_err_r    <= err_r;
                    m0_rdata_r  <= mem_rd;
                end
            end
        end
    end

    // Memory port: active only in ACC; illegal masks suppress the write.
    always_comb begin
        mem_we  = 1'b0;
        mem_amp = 4'b0000;
        mem_a   = {XLEN{1'b0}};
        mem_wd  = {XLEN{1'b0}};
        if (state_r == ACC) begin
            mem_we  = we_r && !err_r;
            mem_amp = amp_r;
            mem_a   = addr_r;
            mem_wd  = wdata_r;
        end else begin
            mem_we  = 1'b0;
            mem_amp = 4'b0000;
            mem_a   = {XLEN{1'b0}};
            mem_wd  = {XLEN{1'b0}};
        end
    end

    assign m0_rvalid = m0_rvalid_r;
    assign m1_rvalid = m1_rvalid_r;
    assign m0_err    = m0_err_r;
    assign m1_err    = m1_err_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_rdata  = m1_rdata_r;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports m0_req/m1_req  input  1  access request from core (m0) and DMA (m1).
REQ-005 SHALL have ports m0_we/m1_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports m0_amp/m1_amp  input  4  byte-lane mask.
REQ-007 SHALL have ports m0_addr/m1_addr  input  XLEN  byte address.
REQ-008 SHALL have ports m0_wdata/m1_wdata  input  XLEN  store data, lane-0-justified for sb/sh.
REQ-009 SHALL have ports m0_gnt/m1_gnt  output  1  request accepted this cycle.
REQ-010 SHALL have ports m0_rvalid/m1_rvalid  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports m0_rdata/m1_rdata  output  XLEN  full word read at the access address.
REQ-012 SHALL have ports m0_err/m1_err  output  1  illegal mask, qualified by rvalid.
REQ-013 SHALL have ports mem_we  output  1, mem_amp  output  4, mem_a  output  XLEN, mem_wd  output  XLEN; these drive the data memory.
REQ-014 SHALL have port mem_rd  input  XLEN  combinational memory read data.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, RESP with transitions IDLE->ACC on any req, ACC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 SHALL, in IDLE with a req present, assert exactly one gnt combinationally and latch the winner's we/amp/addr/wdata and id at the clock edge.
REQ-017 SHALL arbitrate round-robin: a lone requester wins; with both requesting, the master not granted last wins; the last-granted pointer resets to m1 so m0 wins the first tie.
REQ-018 SHALL hold gnt low in ACC and RESP; requesters keep req and fields stable until gnt.
REQ-019 SHALL treat as legal only amp values 1111, 0011, 1100, 0001, 0010, 0100, 1000; any other value flags err.
REQ-020 SHALL, in ACC, drive mem_a/mem_amp/mem_wd from the latched fields and set mem_we = latched we AND NOT err.
REQ-021 SHALL, when not in ACC, drive mem_we=0, mem_amp=0, mem_a=0, mem_wd=0.
REQ-022 SHALL, in ACC, capture mem_rd into a response register at the clock edge for loads and stores alike.
REQ-023 SHALL, in RESP, pulse rvalid for one cycle to the latched id only, with rdata = captured word and err = latched err.
REQ-024 SHALL drive the non-selected master's rvalid/err to 0 and hold its rdata at the last value.
REQ-025 SHALL have a fixed latency of gnt edge + 2 cycles to rvalid, throughput one access per 3 cycles, and a worst-case wait of one foreign access under contention.
REQ-026 SHALL ignore req changes during ACC/RESP; a req still high in RESP is arbitrated in the following IDLE cycle.

Reset
REQ-027 SHALL, on reset assertion at any time, force state=IDLE and pointer=m1, clear all latched fields and response registers, and drive all outputs to 0 immediately.
REQ-028 SHALL ensure that reset during ACC commits no write: mem_we drops asynchronously and no rvalid is issued for the aborted access.

Verification
REQ-029 SHALL cover: m0 sw addr 0x10 wdata 0xDEADBEEF amp 1111 -> m0_gnt in cycle 0, mem_we=1 in cycle 1, m0_rvalid in cycle 2, m0_err=0; a subsequent m0 load at 0x10 returns 0xDEADBEEF.
REQ-030 SHALL cover: m0 and m1 requesting in the same cycle after reset -> order m0, m1, m0, m1 on repeated contention, with no master waiting more than one access.
REQ-031 SHALL cover: m1 sb amp 0100 wdata 0x000000AB at 0x20 over 0x11223344 -> a later read returns 0x11AB3344.
REQ-032 SHALL cover: m0 store with amp 0110 -> mem_we stays 0 throughout, m0_rvalid=1 with m0_err=1, and memory is unchanged.
REQ-033 SHALL cover: reset asserted mid-ACC of a store -> outputs 0 immediately, target word unchanged, no rvalid, and the next request is granted normally after reset release.
